// File: rtl/ticket_vend_ctrl_if.sv
// Bus bundle for ticket_vend_ctrl: selection, coins, buttons, calculator operands/results,
// ticket and change handshakes, and status. The controller connects through the slave modport.
interface ticket_vend_ctrl_if #(
    parameter int W = 8
);
    logic         sel_valid;
    logic [W-1:0] sel_price;
    logic [W-1:0] sel_count;
    logic         coin_valid;
    logic [W-1:0] coin_value;
    logic         confirm;
    logic         cancel;
    logic [W-1:0] calc_coin;
    logic [W-1:0] calc_price;
    logic [W-1:0] calc_count;
    logic [W-1:0] calc_ticket;
    logic [W-1:0] calc_change;
    logic         tkt_valid;
    logic         tkt_ready;
    logic         chg_valid;
    logic [W-1:0] chg_amount;
    logic         chg_ready;
    logic [W-1:0] credit;
    logic         busy;
    logic         coin_reject;
    logic         done;

    modport slave (
        input  sel_valid, sel_price, sel_count,
        input  coin_valid, coin_value, confirm, cancel,
        output calc_coin, calc_price, calc_count,
        input  calc_ticket, calc_change,
        output tkt_valid,
        input  tkt_ready,
        output chg_valid, chg_amount,
        input  chg_ready,
        output credit, busy, coin_reject, done
    );

    modport master (
        output sel_valid, sel_price, sel_count,
        output coin_valid, coin_value, confirm, cancel,
        input  calc_coin, calc_price, calc_count,
        output calc_ticket, calc_change,
        input  tkt_valid,
        output tkt_ready,
        input  chg_valid, chg_amount,
        output chg_ready,
        input  credit, busy, coin_reject, done
    );
endinterface

// File: rtl/ticket_vend_ctrl.sv
// Ticket vending controller: collects coins, runs one external calculation, dispenses tickets, returns change.
// Optional idle-collect timeout enabled by defining TICKET_VEND_TIMEOUT_EN.
module ticket_vend_ctrl #(
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst_n,
    ticket_vend_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CALC,
        DISPENSE,
        CHANGE
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] price_q, price_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] credit_q, credit_d;
    logic [W-1:0] remaining_q, remaining_d;
    logic [W-1:0] refund_q, refund_d;
    logic [W-1:0] calc_coin_q, calc_coin_d;
    logic [W-1:0] calc_price_q, calc_price_d;
    logic [W-1:0] calc_count_q, calc_count_d;
    logic         coin_reject_q, coin_reject_d;
    logic         done_q, done_d;
    logic [W:0]   coin_sum;
    logic         timed_out;

`ifdef TICKET_VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          quiet;

    assign quiet = !(bus.coin_valid || bus.confirm || bus.cancel);

    // Counts consecutive quiet COLLECT cycles; the TIMEOUT-th one behaves like cancel.
    always_comb begin
        idle_d    = '0;
        timed_out = 1'b0;
        if (state_q == COLLECT && quiet) begin
            if (idle_q == IDLE_LAST) begin
                timed_out = 1'b1;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT;

    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        price_d       = price_q;
        count_d       = count_q;
        credit_d      = credit_q;
        remaining_d   = remaining_q;
        refund_d      = refund_q;
        calc_coin_d   = calc_coin_q;
        calc_price_d  = calc_price_q;
        calc_count_d  = calc_count_q;
        coin_reject_d = 1'b0;
        done_d        = 1'b0;
        coin_sum      = {1'b0, credit_q} + {1'b0, bus.coin_value};

        case (state_q)
            IDLE: begin
                if (bus.sel_valid) begin
                    price_d = bus.sel_price;
                    count_d = bus.sel_count;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.coin_valid) begin
                    if (coin_sum[W]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[W-1:0];
                    end
                end
                // A zero price can buy nothing, so confirm degenerates into a refund.
                if (bus.cancel || timed_out || (bus.confirm && price_q == '0)) begin
                    refund_d = credit_d;
                    state_d  = CHANGE;
                end else if (bus.confirm) begin
                    calc_coin_d  = credit_d;
                    calc_price_d = price_q;
                    calc_count_d = count_q;
                    state_d      = CALC;
                end
            end
            CALC: begin
                remaining_d = bus.calc_ticket;
                refund_d    = bus.calc_change;
                state_d     = (bus.calc_ticket != '0) ? DISPENSE : CHANGE;
            end
            DISPENSE: begin
                if (bus.tkt_ready) begin
                    remaining_d = remaining_q - W'(1);
                    if (remaining_q == W'(1)) begin
                        state_d = CHANGE;
                    end
                end
            end
            CHANGE: begin
                if (refund_q == '0 || bus.chg_ready) begin
                    credit_d = '0;
                    refund_d = '0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            price_q       <= '0;
            count_q       <= '0;
            credit_q      <= '0;
            remaining_q   <= '0;
            refund_q      <= '0;
            calc_coin_q   <= '0;
            calc_price_q  <= '0;
            calc_count_q  <= '0;
            coin_reject_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            price_q       <= price_d;
            count_q       <= count_d;
            credit_q      <= credit_d;
            remaining_q   <= remaining_d;
            refund_q      <= refund_d;
            calc_coin_q   <= calc_coin_d;
            calc_price_q  <= calc_price_d;
            calc_count_q  <= calc_count_d;
            coin_reject_q <= coin_reject_d;
            done_q        <= done_d;
        end
    end

    assign bus.calc_coin   = calc_coin_q;
    assign bus.calc_price  = calc_price_q;
    assign bus.calc_count  = calc_count_q;
    assign bus.tkt_valid   = (state_q == DISPENSE);
    assign bus.chg_valid   = (state_q == CHANGE) && (refund_q != '0);
    assign bus.chg_amount  = bus.chg_valid ? refund_q : '0;
    assign bus.credit      = credit_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.coin_reject = coin_reject_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Scoreboard bench for ticket_vend_ctrl: expected ticket/change/done/reject events are queued
// as stimulus is driven and popped by a monitor as the controller produces them.
module tb_ticket_vend_ctrl;
    localparam int W = 8;

    localparam int KIND_TKT  = 0;
    localparam int KIND_CHG  = 1;
    localparam int KIND_DONE = 2;
    localparam int KIND_REJ  = 3;

    typedef struct {
        int           kind;
        logic [W-1:0] value;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    sb_entry_t sb[$];

    logic [W-1:0] model_quot;
    logic [W-1:0] model_tkt;

    ticket_vend_ctrl_if #(.W(W)) vif ();

    ticket_vend_ctrl #(
        .W      (W),
        .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (vif)
    );

    always #5 clk = ~clk;

    // External calculator: ticket = min(count, coin/price), change = coin - ticket*price.
    always_comb begin
        model_quot = (vif.calc_price == '0) ? '0 : vif.calc_coin / vif.calc_price;
        model_tkt  = (model_quot < vif.calc_count) ? model_quot : vif.calc_count;
    end
    assign vif.calc_ticket = model_tkt;
    assign vif.calc_change = vif.calc_coin - model_tkt * vif.calc_price;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input int kind, input logic [W-1:0] value);
        sb_entry_t e;
        e.kind  = kind;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic expectEvent(input string tag, input int kind, input logic [W-1:0] value);
        sb_entry_t e;
        if (sb.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 1, 0);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_kind"}, kind, e.kind);
            if (kind == KIND_CHG) begin
                checkOutput("chg_amount", value, e.value);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (vif.tkt_valid && vif.tkt_ready) expectEvent("tkt", KIND_TKT, '0);
            if (vif.chg_valid && vif.chg_ready) expectEvent("chg", KIND_CHG, vif.chg_amount);
            if (vif.done) expectEvent("done", KIND_DONE, '0);
            if (vif.coin_reject) expectEvent("reject", KIND_REJ, '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input logic [W-1:0] price, input logic [W-1:0] count,
                                 input logic coin, input logic [W-1:0] value,
                                 input logic conf, input logic canc);
        vif.sel_valid  = sel;
        vif.sel_price  = price;
        vif.sel_count  = count;
        vif.coin_valid = coin;
        vif.coin_value = value;
        vif.confirm    = conf;
        vif.cancel     = canc;
        tick();
        vif.sel_valid  = 1'b0;
        vif.coin_valid = 1'b0;
        vif.confirm    = 1'b0;
        vif.cancel     = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (vif.busy && n < budget) begin
            tick();
            n++;
        end
        checkOutput("idle_reached", vif.busy, 0);
        tick();
        checkOutput("sb_drained", sb.size(), 0);
        checkOutput("credit_cleared", vif.credit, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, vif.busy, 0);
        checkOutput({tag, "_credit"}, vif.credit, 0);
        checkOutput({tag, "_tkt_valid"}, vif.tkt_valid, 0);
        checkOutput({tag, "_chg_valid"}, vif.chg_valid, 0);
        checkOutput({tag, "_chg_amount"}, vif.chg_amount, 0);
        checkOutput({tag, "_calc_coin"}, vif.calc_coin, 0);
        checkOutput({tag, "_calc_price"}, vif.calc_price, 0);
        checkOutput({tag, "_calc_count"}, vif.calc_count, 0);
        checkOutput({tag, "_coin_reject"}, vif.coin_reject, 0);
        checkOutput({tag, "_done"}, vif.done, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vif.sel_valid  = 1'b0;
        vif.sel_price  = '0;
        vif.sel_count  = '0;
        vif.coin_valid = 1'b0;
        vif.coin_value = '0;
        vif.confirm    = 1'b0;
        vif.cancel     = 1'b0;
        vif.tkt_ready  = 1'b1;
        vif.chg_ready  = 1'b1;

        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] coins and buttons while idle");
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b1, 1'b1);
        checkOutput("idle_busy", vif.busy, 0);
        checkOutput("idle_credit", vif.credit, 0);
        tick();

        $display("[TB] price 3 count 114 coin 4");
        applyStimulus(1'b1, 8'd3, 8'd114, 1'b0, 8'd0, 1'b0, 1'b0);
        checkOutput("s1_busy", vif.busy, 1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd4, 1'b0, 1'b0);
        checkOutput("s1_credit", vif.credit, 4);
        pushExp(KIND_TKT, '0);
        pushExp(KIND_CHG, 8'd1);
        pushExp(KIND_DONE, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        checkOutput("s1_calc_coin", vif.calc_coin, 4);
        checkOutput("s1_calc_price", vif.calc_price, 3);
        checkOutput("s1_calc_count", vif.calc_count, 114);
        waitIdle(20);

        $display("[TB] price 12 count 200 coins 20 and 250");
        applyStimulus(1'b1, 8'd12, 8'd200, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd20, 1'b0, 1'b0);
        pushExp(KIND_REJ, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd250, 1'b0, 1'b0);
        checkOutput("s2_reject_pulse", vif.coin_reject, 1);
        checkOutput("s2_credit_kept", vif.credit, 20);
        pushExp(KIND_TKT, '0);
        pushExp(KIND_CHG, 8'd8);
        pushExp(KIND_DONE, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        waitIdle(20);

        $display("[TB] credit reaching 255 then overflow");
        applyStimulus(1'b1, 8'd50, 8'd10, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd200, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd55, 1'b0, 1'b0);
        checkOutput("max_credit", vif.credit, 255);
        pushExp(KIND_REJ, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0);
        checkOutput("max_credit_kept", vif.credit, 255);
        for (int i = 0; i < 5; i++) pushExp(KIND_TKT, '0);
        pushExp(KIND_CHG, 8'd5);
        pushExp(KIND_DONE, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        waitIdle(30);

        $display("[TB] price 12 coin 6 with change stalled");
        vif.chg_ready = 1'b0;
        applyStimulus(1'b1, 8'd12, 8'd4, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd6, 1'b1, 1'b0);
        checkOutput("s3_calc_coin", vif.calc_coin, 6);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("s3_chg_held", vif.chg_valid, 1);
            checkOutput("s3_chg_value", vif.chg_amount, 6);
            checkOutput("s3_no_tkt", vif.tkt_valid, 0);
            tick();
        end
        pushExp(KIND_CHG, 8'd6);
        pushExp(KIND_DONE, '0);
        vif.chg_ready = 1'b1;
        waitIdle(20);

        $display("[TB] price 12 coin 0");
        applyStimulus(1'b1, 8'd12, 8'd5, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0);
        pushExp(KIND_DONE, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        waitIdle(20);

        $display("[TB] price 5 coin 7 confirm with cancel");
        applyStimulus(1'b1, 8'd5, 8'd2, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd7, 1'b0, 1'b0);
        pushExp(KIND_CHG, 8'd7);
        pushExp(KIND_DONE, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);
        checkOutput("s4_calc_hold", vif.calc_price, 12);
        waitIdle(20);

        $display("[TB] price 0 confirm acts as cancel");
        applyStimulus(1'b1, 8'd0, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b0, 1'b0);
        pushExp(KIND_CHG, 8'd5);
        pushExp(KIND_DONE, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        checkOutput("zero_price_calc_hold", vif.calc_price, 12);
        waitIdle(20);

        $display("[TB] price 2 count 3 coin 10, stall then reset");
        vif.tkt_ready = 1'b0;
        applyStimulus(1'b1, 8'd2, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd10, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        checkOutput("s5_calc_coin", vif.calc_coin, 10);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("s5_tkt_held", vif.tkt_valid, 1);
            tick();
        end
        pushExp(KIND_TKT, '0);
        vif.tkt_ready = 1'b1;
        tick();
        vif.tkt_ready = 1'b0;
        checkOutput("s5_still_dispensing", vif.tkt_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        vif.tkt_ready = 1'b1;
        tick();
        checkOutput("midreset_idle", vif.busy, 0);
        checkOutput("midreset_sb", sb.size(), 0);

        $display("[TB] price 4 count 2 coin 9 after reset");
        applyStimulus(1'b1, 8'd4, 8'd2, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd9, 1'b0, 1'b0);
        pushExp(KIND_TKT, '0);
        pushExp(KIND_TKT, '0);
        pushExp(KIND_CHG, 8'd1);
        pushExp(KIND_DONE, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        waitIdle(20);

`ifdef TICKET_VEND_TIMEOUT_EN
        $display("[TB] coin 9 then quiet until timeout");
        applyStimulus(1'b1, 8'd7, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd9, 1'b0, 1'b0);
        pushExp(KIND_CHG, 8'd9);
        pushExp(KIND_DONE, '0);
        repeat (15) tick();
        checkOutput("to_not_yet", vif.chg_valid, 0);
        checkOutput("to_collecting", vif.credit, 9);
        tick();
        checkOutput("to_fired", vif.chg_valid, 1);
        waitIdle(20);
`else
        $display("[TB] coin 9 then long quiet wait");
        applyStimulus(1'b1, 8'd7, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd9, 1'b0, 1'b0);
        repeat (40) tick();
        checkOutput("wait_busy", vif.busy, 1);
        checkOutput("wait_credit", vif.credit, 9);
        checkOutput("wait_no_chg", vif.chg_valid, 0);
        pushExp(KIND_CHG, 8'd9);
        pushExp(KIND_DONE, '0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
        waitIdle(20);
`endif

        checkOutput("sb_final", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
